fb_pattern_writer: RTL and testbench
====================================

# fb_pattern_writer

Parametrised framebuffer test-pattern engine that walks every write position of a monochrome framebuffer and writes a selectable pattern using the framebuffer's write handshake (`fb_we` / `fb_w_data_valid` / `fb_busy`). It replaces ad-hoc single-pattern writers in top-level designs. It sits between a top-level controller (buttons, LEDs) and the framebuffer write port, alongside the OLED driver, which owns the read port. It adds the following:
- Configurable geometry and pacing.
- Four pattern modes.
- Single-frame and continuous operation.
- Per-frame inversion, abort, and status outputs.

## Interface
Parameters:
- `FB_WIDTH`, default 128: write positions per row; x runs 0..FB_WIDTH-1.
- `FB_HEIGHT`, default 64: rows; y runs 0..FB_HEIGHT-1.
- `COORD_W`, default 8: width of the x/y coordinate ports.
- `TICK_DIV`, default 27000: clk cycles between successive writes. A value of 0 means back-to-back writes.
- `ACK_TIMEOUT`, default 1023: acknowledge watchdog limit in cycles. Used only with the macro below.

Ports:
- `clk`  in  1  system clock (27 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame when IDLE. Ignored otherwise.
- `continuous`  in  1  level; when high at frame end, the next frame starts automatically.
- `abort`  in  1  pulse; returns the block to IDLE after any outstanding write.
- `mode`  in  2  pattern select; sampled at every frame start.
- `auto_invert`  in  1  level; when high, the invert flag toggles at each frame end.
- `fb_busy`  in  1  framebuffer busy.
- `fb_w_data_valid`  in  1  framebuffer write acknowledge.
- `fb_we`  out  1  write enable; held until acknowledged.
- `fb_w_xpos`  out  COORD_W  write x.
- `fb_w_ypos`  out  COORD_W  write y.
- `fb_din`  out  8  write data (8 pixels).
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the last write of a frame is acknowledged.
- `error`  out  1  sticky ack-timeout flag. Tied to 0 without the macro.

## Operation
- States: IDLE, WAIT_TICK, ISSUE, WAIT_ACK, ADVANCE.
- IDLE: on `start`, do the following and go to WAIT_TICK:
  - clear x, y and the tick counter;
  - latch `mode`;
  - keep the invert flag.
- WAIT_TICK: the counter increments each cycle. When it reaches `TICK_DIV`, or immediately if `TICK_DIV`=0, clear it and go to ISSUE.
- ISSUE: wait while `fb_busy`=1. On the first edge with `fb_busy`=0, register `fb_we`=1 together with x, y and the pattern byte, then go to WAIT_ACK.
- WAIT_ACK: hold `fb_we`, address and data stable. On the edge where `fb_w_data_valid`=1, clear `fb_we` and go to ADVANCE.
- ADVANCE:
  - If x < FB_WIDTH-1: x += 1, then go to WAIT_TICK.
  - Otherwise x = 0. If y < FB_HEIGHT-1: y += 1, then go to WAIT_TICK.
  - Otherwise y = 0 and the frame ends:
    - pulse `frame_done`;
    - toggle the invert flag if `auto_invert`;
    - if `continuous`: re-latch `mode` and go to WAIT_TICK; else go to IDLE.
- Pattern byte P, XORed with 8'hFF when the invert flag is set:
  - mode 0 (solid): 8'hFF.
  - mode 1 (checker): 8'hAA if x[0]^y[0], else 8'h55.
  - mode 2 (h-bars): 8'hFF if y[3], else 8'h00.
  - mode 3 (v-stripes): 8'hFF if x[3], else 8'h00.
- Abort:
  - In IDLE: no effect.
  - In WAIT_TICK or ISSUE (before `fb_we` rises): go to IDLE next cycle.
  - In WAIT_ACK: latch the request and complete the handshake, then go to IDLE instead of ADVANCE. No `frame_done` is issued.
- `start` while busy is ignored. `start` and `abort` in the same IDLE cycle: `abort` wins.
- Coordinate arithmetic is done in COORD_W bits. FB_WIDTH-1 and FB_HEIGHT-1 must be ≤ 2^COORD_W-1.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE;
  - `fb_we`=0;
  - `fb_w_xpos`=0, `fb_w_ypos`=0, `fb_din`=0;
  - `busy`=0, `frame_done`=0, `error`=0;
  - invert flag 0, tick counter 0.
- Reset mid-handshake drops `fb_we` immediately.
- `start` to first `fb_we`=1 is TICK_DIV+2 cycles with `fb_busy`=0. With TICK_DIV=0 it is 2 cycles.
- Per-write period with an immediate ack and TICK_DIV=0 is 4 cycles (TICK→ISSUE→WAIT_ACK→ADVANCE).
- `frame_done` is asserted the cycle after the final ack edge.
- `busy` falls in the same cycle the state enters IDLE.

## Configuration
- `FB_PATTERN_WRITER_TIMEOUT_EN` defined:
  - A WAIT_ACK cycle counter is active.
  - If `fb_w_data_valid` has not arrived after ACK_TIMEOUT cycles, drop `fb_we`, set `error`, and go to ADVANCE, so the pixel is skipped.
  - `error` clears only on reset.
- Undefined:
  - No counter; WAIT_ACK waits indefinitely.
  - `error` is constant 0.

## Test plan
- FB_WIDTH=4, FB_HEIGHT=2, TICK_DIV=0, mode 0, ack 1 cycle after `fb_we` → exactly 8 writes in order (0,0)..(3,0),(0,1)..(3,1), all `fb_din`=8'hFF; single `frame_done`; `busy`=0 afterwards.
- Same geometry, mode 1 → `fb_din` sequence 55,AA,55,AA,AA,55,AA,55.
- TICK_DIV=3, `fb_busy` held high for 10 cycles at the first ISSUE → `fb_we` rises on the first edge after `fb_busy` falls; address and data stay stable until the ack arrives 5 cycles later.
- `continuous`=1, `auto_invert`=1, mode 0 → frame 1 writes FF, frame 2 writes 00, frame 3 writes FF; `mode` is changed mid-frame to 2 and takes effect only at frame 2.
- `abort` asserted during WAIT_ACK of write (2,0) → the write completes on ack, then IDLE with no further `fb_we` and no `frame_done`. A new `start` restarts at (0,0).
- Macro defined, ACK_TIMEOUT=7, ack withheld on write (1,0) → `fb_we` drops after 7 cycles, `error`=1, and the next write is (2,0). `rst_n` low clears `error` and `fb_we` asynchronously.

Source files
------------

// File: rtl/fb_pattern_writer.sv
// rtl/fb_pattern_writer.sv - framebuffer test-pattern writer walking every write position
// Optional ack watchdog: define FB_PATTERN_WRITER_TIMEOUT_EN.
module fb_pattern_writer #(
   parameter int FB_WIDTH    = 128,
   parameter int FB_HEIGHT   = 64,
   parameter int COORD_W     = 8,
   parameter int TICK_DIV    = 27000,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               continuous,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic               auto_invert,
   input  logic               fb_busy,
   input  logic               fb_w_data_valid,
   output logic               fb_we,
   output logic [COORD_W-1:0] fb_w_xpos,
   output logic [COORD_W-1:0] fb_w_ypos,
   output logic [7:0]         fb_din,
   output logic               busy,
   output logic               frame_done,
   output logic               error
);

   localparam int TICK_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV);
   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(FB_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(FB_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ISSUE,
      S_WAIT_ACK,
      S_ADVANCE
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0]  xpos_q, xpos_d, ypos_q, ypos_d;
   logic [7:0]          din_q, din_d;
   logic [1:0]          mode_q, mode_d;
   logic                inv_q, inv_d;
   logic                abort_q, abort_d;
   logic                we_q, we_d;
   logic                done_q, done_d;
   logic                timeout;
   logic                last_pos;
   logic [7:0]          pattern;

   assign last_pos = (x_q == X_LAST) && (y_q == Y_LAST);

   always_comb begin
      pattern = 8'h00;
      case (mode_q)
         2'd0:    pattern = 8'hFF;
         2'd1:    pattern = (x_q[0] ^ y_q[0]) ? 8'hAA : 8'h55;
         2'd2:    pattern = y_q[3] ? 8'hFF : 8'h00;
         default: pattern = x_q[3] ? 8'hFF : 8'h00;
      endcase
      if (inv_q) pattern = pattern ^ 8'hFF;
   end

`ifdef FB_PATTERN_WRITER_TIMEOUT_EN
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             err_q, err_d;

   // Counter holds the number of WAIT_ACK cycles already spent without an ack.
   assign timeout = (state_q == S_WAIT_ACK) && !fb_w_data_valid && (ack_cnt_q >= ACK_LAST);

   always_comb begin
      ack_cnt_d = ack_cnt_q;
      err_d     = err_q;
      if (state_q != S_WAIT_ACK) ack_cnt_d = '0;
      else if (!fb_w_data_valid && ack_cnt_q < ACK_LAST) ack_cnt_d = ack_cnt_q + 1'b1;
      if (timeout) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         ack_cnt_q <= ack_cnt_d;
         err_q     <= err_d;
      end
   end

   assign error = err_q;
`else
   logic [31:0] unused_ack_timeout;
   assign unused_ack_timeout = ACK_TIMEOUT;
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      x_d     = x_q;
      y_d     = y_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      din_d   = din_q;
      mode_d  = mode_q;
      inv_d   = inv_q;
      abort_d = abort_q;
      we_d    = we_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (start && !abort) begin
               x_d     = '0;
               y_d     = '0;
               tick_d  = '0;
               mode_d  = mode;
               state_d = S_WAIT_TICK;
            end
         end
         S_WAIT_TICK: begin
            if (abort) begin
               tick_d  = '0;
               state_d = S_IDLE;
            end else if (tick_q >= TICK_LAST) begin
               tick_d  = '0;
               state_d = S_ISSUE;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!fb_busy) begin
               we_d    = 1'b1;
               xpos_d  = x_q;
               ypos_d  = y_q;
               din_d   = pattern;
               abort_d = 1'b0;
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            abort_d = abort_q | abort;
            // A timed-out write is treated like an ack so the pixel is skipped.
            if (fb_w_data_valid || timeout) begin
               we_d = 1'b0;
               if (abort_q || abort) begin
                  state_d = S_IDLE;
               end else begin
                  done_d  = last_pos;
                  state_d = S_ADVANCE;
               end
            end
         end
         S_ADVANCE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (x_q < X_LAST) begin
               x_d     = x_q + 1'b1;
               state_d = S_WAIT_TICK;
            end else begin
               x_d = '0;
               if (y_q < Y_LAST) begin
                  y_d     = y_q + 1'b1;
                  state_d = S_WAIT_TICK;
               end else begin
                  y_d = '0;
                  if (auto_invert) inv_d = ~inv_q;
                  if (continuous) begin
                     mode_d  = mode;
                     state_d = S_WAIT_TICK;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         xpos_q  <= '0;
         ypos_q  <= '0;
         din_q   <= '0;
         mode_q  <= '0;
         inv_q   <= 1'b0;
         abort_q <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         din_q   <= din_d;
         mode_q  <= mode_d;
         inv_q   <= inv_d;
         abort_q <= abort_d;
         we_q    <= we_d;
         done_q  <= done_d;
      end
   end

   assign fb_we      = we_q;
   assign fb_w_xpos  = xpos_q;
   assign fb_w_ypos  = ypos_q;
   assign fb_din     = din_q;
   assign frame_done = done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb/tb_fb_pattern_writer.sv - scoreboard bench for fb_pattern_writer on a 4x2 framebuffer
module tb_fb_pattern_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       auto_invert = 1'b0;
   logic       fb_busy = 1'b0;
   logic       fb_w_data_valid = 1'b0;
   logic       fb_we;
   logic [7:0] fb_w_xpos, fb_w_ypos, fb_din;
   logic       busy, frame_done, error;

   fb_pattern_writer #(
      .FB_WIDTH(4), .FB_HEIGHT(2), .COORD_W(8), .TICK_DIV(3), .ACK_TIMEOUT(7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
      .mode(mode), .auto_invert(auto_invert), .fb_busy(fb_busy),
      .fb_w_data_valid(fb_w_data_valid), .fb_we(fb_we), .fb_w_xpos(fb_w_xpos),
      .fb_w_ypos(fb_w_ypos), .fb_din(fb_din), .busy(busy), .frame_done(frame_done),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] d;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   ack_delay = 1;
   int   ack_cnt = 0;
   logic withhold = 1'b0;
   logic [7:0] wh_x = 8'd0, wh_y = 8'd0;
   logic we_prev = 1'b0;

   logic [7:0] checker_tbl [8] = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame_const(input logic [7:0] d);
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         e.x = 8'(i % 4); e.y = 8'(i / 4); e.d = d;
         q.push_back(e);
      end
   endtask

   task automatic push_one(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
      exp_t e;
      e.x = x; e.y = y; e.d = d;
      q.push_back(e);
   endtask

   // Monitor: each rising fb_we is one write, checked against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fb_we && !we_prev) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_write: got x=%0d y=%0d d=%0h expected no write",
                        fb_w_xpos, fb_w_ypos, fb_din);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("wr_x", 32'(fb_w_xpos), 32'(e.x));
               chk("wr_y", 32'(fb_w_ypos), 32'(e.y));
               chk("wr_din", 32'(fb_din), 32'(e.d));
            end
         end
         if (frame_done) done_cnt++;
      end
      we_prev = fb_we;
   end

   // Framebuffer ack responder with programmable delay and optional withheld position.
   always @(negedge clk) begin
      if (fb_we && !(withhold && fb_w_xpos == wh_x && fb_w_ypos == wh_y)) begin
         if (ack_cnt + 1 >= ack_delay) begin
            fb_w_data_valid = 1'b1;
            ack_cnt = 0;
         end else begin
            ack_cnt++;
         end
      end else begin
         fb_w_data_valid = 1'b0;
         ack_cnt = 0;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; continuous = 1'b0; auto_invert = 1'b0;
      mode = 2'd0; fb_busy = 1'b0; withhold = 1'b0; ack_delay = 1;
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 3000) begin @(negedge clk); k++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_write_at(input logic [7:0] x, input logic [7:0] y);
      int k = 0;
      while (!(fb_we && fb_w_xpos == x && fb_w_ypos == y) && k < 2000) begin
         @(negedge clk); k++;
      end
      chk("write_seen", 32'(fb_we && fb_w_xpos == x && fb_w_ypos == y), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, hi, k;
      logic stable;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(fb_we), 32'd0);
      chk("rst_x", 32'(fb_w_xpos), 32'd0);
      chk("rst_y", 32'(fb_w_ypos), 32'd0);
      chk("rst_din", 32'(fb_din), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      do_reset();

      // Solid frame and start latency (TICK_DIV+2)
      push_frame_const(8'hFF);
      pulse_start();
      lat = 0;
      while (!fb_we && lat < 50) begin @(negedge clk); lat++; end
      chk("start_latency", 32'(lat), 32'd5);
      wait_idle("solid_idle");
      chk("solid_done", 32'(done_cnt), 32'd1);
      chk("solid_sb_empty", 32'(q.size()), 32'd0);

      // Checkerboard
      done_cnt = 0;
      mode = 2'd1;
      for (int i = 0; i < 8; i++) push_one(8'(i % 4), 8'(i / 4), checker_tbl[i]);
      pulse_start();
      wait_idle("checker_idle");
      chk("checker_done", 32'(done_cnt), 32'd1);
      chk("checker_sb_empty", 32'(q.size()), 32'd0);

      // fb_busy stall at first ISSUE, slow ack
      do_reset();
      ack_delay = 5;
      fb_busy = 1'b1;
      push_frame_const(8'hFF);
      pulse_start();
      repeat (14) @(negedge clk);
      chk("we_held_by_busy", 32'(fb_we), 32'd0);
      fb_busy = 1'b0;
      @(negedge clk);
      chk("we_after_busy", 32'(fb_we), 32'd1);
      hi = 0; stable = 1'b1;
      while (fb_we && hi < 20) begin
         stable &= (fb_w_xpos == 8'd0 && fb_w_ypos == 8'd0 && fb_din == 8'hFF);
         hi++;
         @(negedge clk);
      end
      chk("ack_wait_cycles", 32'(hi), 32'd5);
      chk("addr_data_stable", 32'(stable), 32'd1);
      wait_idle("stall_idle");
      chk("stall_sb_empty", 32'(q.size()), 32'd0);

      // Continuous with auto-invert
      do_reset();
      continuous = 1'b1; auto_invert = 1'b1;
      push_frame_const(8'hFF);
      push_frame_const(8'h00);
      push_frame_const(8'hFF);
      pulse_start();
      k = 0;
      while (done_cnt < 2 && k < 3000) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      continuous = 1'b0;
      wait_idle("cont_idle");
      chk("cont_done", 32'(done_cnt), 32'd3);
      chk("cont_sb_empty", 32'(q.size()), 32'd0);

      // Mode change mid-frame applies from the next frame
      do_reset();
      continuous = 1'b1;
      push_frame_const(8'hFF);
      push_frame_const(8'h00);
      pulse_start();
      k = 0;
      while (q.size() > 13 && k < 2000) begin @(negedge clk); k++; end
      mode = 2'd2;
      k = 0;
      while (done_cnt < 1 && k < 2000) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      continuous = 1'b0;
      wait_idle("mode_idle");
      chk("mode_done", 32'(done_cnt), 32'd2);
      chk("mode_sb_empty", 32'(q.size()), 32'd0);

      // Abort during WAIT_ACK of (2,0), then restart
      do_reset();
      ack_delay = 3;
      push_one(8'd0, 8'd0, 8'hFF);
      push_one(8'd1, 8'd0, 8'hFF);
      push_one(8'd2, 8'd0, 8'hFF);
      pulse_start();
      wait_write_at(8'd2, 8'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle("abort_idle");
      repeat (20) @(negedge clk);
      chk("abort_stays_idle", 32'(busy), 32'd0);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_sb_empty", 32'(q.size()), 32'd0);
      push_frame_const(8'hFF);
      pulse_start();
      wait_idle("restart_idle");
      chk("restart_done", 32'(done_cnt), 32'd1);
      chk("restart_sb_empty", 32'(q.size()), 32'd0);

      // start+abort together in IDLE, abort in WAIT_TICK
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 32'd0);
      pulse_start();
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("tick_abort_idle", 32'(busy), 32'd0);
      repeat (15) @(negedge clk);
      chk("tick_abort_no_write", 32'(fb_we), 32'd0);

`ifdef FB_PATTERN_WRITER_TIMEOUT_EN
      // Withheld ack on (1,0) times out after 7 cycles; pixel skipped
      do_reset();
      withhold = 1'b1; wh_x = 8'd1; wh_y = 8'd0;
      push_frame_const(8'hFF);
      pulse_start();
      wait_write_at(8'd1, 8'd0);
      hi = 0;
      while (fb_we && hi < 50) begin hi++; @(negedge clk); end
      chk("timeout_cycles", 32'(hi), 32'd7);
      chk("timeout_error", 32'(error), 32'd1);
      wait_idle("timeout_idle");
      chk("timeout_sb_empty", 32'(q.size()), 32'd0);
      chk("timeout_error_sticky", 32'(error), 32'd1);
      wh_x = 8'd0;
`else
      // Without the watchdog a withheld ack stalls forever
      do_reset();
      withhold = 1'b1; wh_x = 8'd1; wh_y = 8'd0;
      push_one(8'd0, 8'd0, 8'hFF);
      push_one(8'd1, 8'd0, 8'hFF);
      pulse_start();
      wait_write_at(8'd1, 8'd0);
      repeat (30) @(negedge clk);
      chk("stall_we_held", 32'(fb_we), 32'd1);
      chk("no_timeout_error", 32'(error), 32'd0);
`endif

      // Asynchronous reset mid-handshake
      withhold = 1'b1;
      if (!fb_we) begin
         q.delete();
         push_one(wh_x, wh_y, 8'hFF);
         pulse_start();
         wait_write_at(wh_x, wh_y);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_we", 32'(fb_we), 32'd0);
      chk("async_rst_error", 32'(error), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      q.delete();
      withhold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
